// File: rtl/multi_tap_loop_recorder_if.sv
// Audio-path bus for the multi-tap loop recorder.
// The master side (sample source / control) drives samples, mode bits and tap settings.
// The slave side (the recorder) returns the mixed sample and status.
interface multi_tap_loop_recorder_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_TAPS     = 2
);
    logic signed [SAMPLE_WIDTH-1:0]        audio_in;
    logic                                  audio_valid_in;
    logic                                  record_in;
    logic                                  play_in;
    logic                                  clear_in;
    logic        [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay_in;
    logic        [NUM_TAPS*3-1:0]          tap_shift_in;
    logic signed [SAMPLE_WIDTH-1:0]        audio_out;
    logic                                  audio_valid_out;
    logic                                  busy_out;
    logic                                  full_out;
    logic                                  overrun_out;
    logic        [ADDR_WIDTH:0]            rec_len_out;

    modport master (
        output audio_in, audio_valid_in, record_in, play_in, clear_in,
               tap_delay_in, tap_shift_in,
        input  audio_out, audio_valid_out, busy_out, full_out, overrun_out,
               rec_len_out
    );

    modport slave (
        input  audio_in, audio_valid_in, record_in, play_in, clear_in,
               tap_delay_in, tap_shift_in,
        output audio_out, audio_valid_out, busy_out, full_out, overrun_out,
               rec_len_out
    );
endinterface

// File: rtl/multi_tap_loop_recorder.sv
// Loop recorder with multi-tap echo.
// Samples are appended into a circular RAM while recording; in play mode each strobe
// reads the dry sample plus NUM_TAPS delayed copies (one RAM read per cycle), sums the
// shift-attenuated taps with the dry sample and saturates the result to the sample range.
// Strobes with neither record nor play pass the input straight through (monitor mode).
module multi_tap_loop_recorder #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_TAPS     = 2
) (
    input logic                      clk_in,
    input logic                      rst_n_in,
    multi_tap_loop_recorder_if.slave bus
);
    localparam int W     = SAMPLE_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int N     = NUM_TAPS;
    localparam int DEPTH = 1 << AW;
    localparam int ACC_W = W + $clog2(N + 1) + 1;
    localparam int IDX_W = $clog2(N + 2);

    localparam logic        [AW:0]      DEPTH_LEN = {1'b1, {AW{1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Sample storage and its registered read port
    logic signed [W-1:0]     mem [DEPTH];
    logic signed [W-1:0]     rd_data;
    logic        [AW-1:0]    rd_addr;

    // Recording / playback bookkeeping
    logic        [AW-1:0]    w_ptr;
    logic        [AW-1:0]    play_ptr;
    logic        [AW:0]      rec_len;
    logic                    write_en;

    // Per-sequence snapshot taken when a play strobe is accepted
    logic        [AW-1:0]    snap_ptr;
    logic        [AW-1:0]    tap_addr [N];
    logic        [AW-1:0]    tap_addr_nxt [N];
    logic        [N-1:0]     tap_en;
    logic        [N-1:0]     tap_en_nxt;
    logic        [2:0]       tap_sh [N];

    // Sequencer and mixer
    state_t                  state;
    logic        [IDX_W-1:0] idx;
    logic        [IDX_W-1:0] term_sel;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [W-1:0]     sat_sample;

    // Registered outputs
    logic signed [W-1:0]     audio_out_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    strobe;
    logic                    busy_state;

    assign strobe     = bus.audio_valid_in;
    assign busy_state = (state == READ) || (state == DRAIN);
    assign write_en   = strobe && bus.record_in && !bus.clear_in && (rec_len != DEPTH_LEN);

    assign bus.audio_out       = audio_out_q;
    assign bus.audio_valid_out = valid_q;
    assign bus.busy_out        = busy_q;
    assign bus.overrun_out     = overrun_q;
    assign bus.full_out        = (rec_len == DEPTH_LEN);
    assign bus.rec_len_out     = rec_len;

    // Append the incoming sample while recording; contents survive reset and clear
    always_ff @(posedge clk_in) begin
        if (write_en) begin
            mem[w_ptr] <= bus.audio_in;
        end
    end

    // One-cycle-latency read port shared by the dry and tap reads
    always_ff @(posedge clk_in) begin
        rd_data <= mem[rd_addr];
    end

    // Tap addresses wrap within the recorded span, not the whole RAM
    always_comb begin
        tap_en_nxt = '0;
        for (int k = 0; k < N; k++) begin
            tap_en_nxt[k] = (bus.tap_delay_in[k*AW +: AW] != '0) &&
                            ({1'b0, bus.tap_delay_in[k*AW +: AW]} < rec_len);
            if (play_ptr >= bus.tap_delay_in[k*AW +: AW]) begin
                tap_addr_nxt[k] = play_ptr - bus.tap_delay_in[k*AW +: AW];
            end else begin
                tap_addr_nxt[k] = AW'({1'b0, play_ptr} + rec_len -
                                      {1'b0, bus.tap_delay_in[k*AW +: AW]});
            end
        end
    end

    // Read index 0 fetches the dry sample, index k+1 fetches tap k
    always_comb begin
        rd_addr = snap_ptr;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k + 1)) begin
                rd_addr = tap_addr[k];
            end
        end
    end

    // Weight the sample just returned by the RAM and add it to the running sum
    always_comb begin
        term_sel = (state == DRAIN) ? IDX_W'(N) : (idx - IDX_W'(1));
        term     = '0;
        if (term_sel == '0) begin
            term = ACC_W'(rd_data);
        end
        for (int k = 0; k < N; k++) begin
            if ((term_sel == IDX_W'(k + 1)) && tap_en[k]) begin
                term = ACC_W'(rd_data) >>> tap_sh[k];
            end
        end
        acc_next = acc + term;
        if (acc_next > SAT_MAX) begin
            sat_sample = {1'b0, {(W-1){1'b1}}};
        end else if (acc_next < SAT_MIN) begin
            sat_sample = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_sample = acc_next[W-1:0];
        end
    end

    // Control FSM: recording bookkeeping, monitor pass-through and the play mix sequence
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            snap_ptr    <= '0;
            play_ptr    <= '0;
            w_ptr       <= '0;
            rec_len     <= '0;
            tap_en      <= '0;
            audio_out_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                tap_addr[k] <= '0;
                tap_sh[k]   <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (bus.clear_in) begin
                state     <= IDLE;
                idx       <= '0;
                acc       <= '0;
                play_ptr  <= '0;
                w_ptr     <= '0;
                rec_len   <= '0;
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (write_en) begin
                    w_ptr   <= w_ptr + AW'(1);
                    rec_len <= rec_len + (AW+1)'(1);
                end
                case (state)
                    IDLE, OUT: begin
                        state <= IDLE;
                        if (strobe && !bus.record_in) begin
                            if (bus.play_in) begin
                                if (rec_len != '0) begin
                                    state    <= READ;
                                    busy_q   <= 1'b1;
                                    idx      <= '0;
                                    acc      <= '0;
                                    snap_ptr <= play_ptr;
                                    tap_en   <= tap_en_nxt;
                                    for (int k = 0; k < N; k++) begin
                                        tap_addr[k] <= tap_addr_nxt[k];
                                        tap_sh[k]   <= bus.tap_shift_in[k*3 +: 3];
                                    end
                                    if (({1'b0, play_ptr} + (AW+1)'(1)) >= rec_len) begin
                                        play_ptr <= '0;
                                    end else begin
                                        play_ptr <= play_ptr + AW'(1);
                                    end
                                end
                            end else begin
                                audio_out_q <= bus.audio_in;
                                valid_q     <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (strobe && !bus.record_in) begin
                            overrun_q <= 1'b1;
                        end
                        if (idx != '0) begin
                            acc <= acc_next;
                        end
                        if (idx == IDX_W'(N)) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (strobe && !bus.record_in) begin
                            overrun_q <= 1'b1;
                        end
                        audio_out_q <= sat_sample;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= OUT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
